// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with run gate and halt.
// Optional PERF_CNT_EN macro adds retired-instruction and active-cycle counters.
module multicycle_control_fsm #(
  parameter int          CNT_W       = 32,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  output logic             SelectIns,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             BEQ,
  output logic [1:0]       PCSrc,
  output logic             PCWrite,
  output logic             instr_done,
  output logic             halted,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I,
    S_WB_ALU, S_MEM_ADDR, S_MEM_RD, S_WB_MEM,
    S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t state, state_nx;
  // Only opcode bits consulted after DECODE: [1] = op[4] (I vs R), [0] = op[0].
  logic [1:0] op_q, op_nx;

  logic sel_r, irw_r, rw_r, rdst_r, asa_r;
  logic mw_r, m2r_r, beq_r, pcw_r;
  logic [1:0] asb_r, pcsrc_r;

  logic is_halt, is_r, is_i, is_br, is_j, is_mem;

  always_comb begin
    is_halt = (opcode == HALT_OPCODE);
    is_r    = ~is_halt & (opcode[5:4] == 2'b00);
    is_i    = ~is_halt & (opcode[5:4] == 2'b01);
    is_br   = ~is_halt & (opcode[5:1] == 5'b10000);
    is_j    = ~is_halt & (opcode == 6'b100010);
    is_mem  = ~is_halt & (opcode[5:1] == 5'b11000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else if (run) begin
      state <= state_nx;
      op_q  <= op_nx;
    end
  end

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    sel_r    = 1'b0;
    irw_r    = 1'b0;
    rw_r     = 1'b0;
    rdst_r   = 1'b0;
    asa_r    = 1'b0;
    asb_r    = 2'b00;
    mw_r     = 1'b0;
    m2r_r    = 1'b0;
    beq_r    = 1'b0;
    pcsrc_r  = 2'b00;
    pcw_r    = 1'b0;
    unique case (state)
      S_FETCH: begin
        irw_r    = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        op_nx = {opcode[4], opcode[0]};
        unique case (1'b1)
          is_halt: state_nx = S_HALT;
          is_r:    state_nx = S_EXEC_R;
          is_i:    state_nx = S_EXEC_I;
          is_br:   state_nx = S_BRANCH;
          is_j:    state_nx = S_JUMP;
          is_mem:  state_nx = S_MEM_ADDR;
          default: begin
            pcw_r    = 1'b1;
            state_nx = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        asa_r    = 1'b1;
        state_nx = S_WB_ALU;
      end
      S_EXEC_I: begin
        asa_r    = 1'b1;
        asb_r    = 2'b10;
        state_nx = S_WB_ALU;
      end
      S_WB_ALU: begin
        rw_r     = 1'b1;
        rdst_r   = 1'b1;
        asa_r    = 1'b1;
        asb_r    = op_q[1] ? 2'b10 : 2'b00;
        pcw_r    = 1'b1;
        state_nx = S_FETCH;
      end
      S_MEM_ADDR: begin
        asa_r    = 1'b1;
        asb_r    = 2'b10;
        state_nx = op_q[0] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        sel_r    = 1'b1;
        state_nx = S_WB_MEM;
      end
      S_WB_MEM: begin
        rw_r     = 1'b1;
        rdst_r   = 1'b1;
        m2r_r    = 1'b1;
        pcw_r    = 1'b1;
        state_nx = S_FETCH;
      end
      S_MEM_WR: begin
        mw_r     = 1'b1;
        pcw_r    = 1'b1;
        state_nx = S_FETCH;
      end
      S_BRANCH: begin
        asa_r    = 1'b1;
        beq_r    = ~op_q[0];
        pcsrc_r  = 2'b01;
        pcw_r    = 1'b1;
        state_nx = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_r  = 2'b10;
        pcw_r    = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  logic live, strobe;
  assign live   = ~reset;
  assign strobe = ~reset & run;

  assign SelectIns  = live & sel_r;
  assign IRWrite    = strobe & irw_r;
  assign RegWrite   = strobe & rw_r;
  assign RegDst     = live & rdst_r;
  assign ALUSrcA    = live & asa_r;
  assign ALUSrcB    = live ? asb_r : 2'b00;
  assign MemWrite   = strobe & mw_r;
  assign MemtoReg   = live & m2r_r;
  assign BEQ        = live & beq_r;
  assign PCSrc      = live ? pcsrc_r : 2'b00;
  assign PCWrite    = strobe & pcw_r;
  assign instr_done = PCWrite;
  assign halted     = live & (state == S_HALT);
  assign state_dbg  = live ? state : 4'd0;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] icnt_q, ccnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (run && state != S_HALT) ccnt_q <= ccnt_q + 1'b1;
      if (instr_done) icnt_q <= icnt_q + 1'b1;
    end
  end

  assign instr_cnt = live ? icnt_q : '0;
  assign cycle_cnt = live ? ccnt_q : '0;
`else
  assign instr_cnt = '0;
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction step model plus directed pins.
// Counter checks follow PERF_CNT_EN when it is defined at compile time.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [5:0]  opcode;
  logic        SelectIns, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc;
  logic        MemWrite, MemtoReg, BEQ, PCWrite, instr_done, halted;
  logic [3:0]  state_dbg;
  logic [31:0] instr_cnt, cycle_cnt;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .SelectIns(SelectIns), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .BEQ(BEQ),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .instr_done(instr_done),
    .halted(halted), .state_dbg(state_dbg),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  localparam int C_R = 0, C_I = 1, C_BR = 2, C_J = 3;
  localparam int C_LW = 4, C_SW = 5, C_HALT = 6, C_ILL = 7;

  int errors = 0;
  int checks = 0;

  // Model: instruction class plus step index within that instruction.
  int          cls = C_ILL;
  int          step = 0;
  logic [5:0]  op_m = '0;
  logic [31:0] m_instr = '0, m_cyc = '0;

  logic [7:0] h_irw, h_rw, h_pcw, h_mw, h_sel, h_m2r;
  logic [1:0] last_pcsrc;
  logic       last_beq;
  int         n_halt;

  function automatic int classify(input logic [5:0] o);
    if (o == 6'b111111) return C_HALT;
    if (o[5:4] == 2'b00) return C_R;
    if (o[5:4] == 2'b01) return C_I;
    case (o)
      6'b100000, 6'b100001: return C_BR;
      6'b100010:            return C_J;
      6'b110000:            return C_LW;
      6'b110001:            return C_SW;
      default:              return C_ILL;
    endcase
  endfunction

  function automatic int ilen(input int c);
    case (c)
      C_LW:       return 5;
      C_BR, C_J:  return 3;
      C_ILL:      return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [14:0] model_out(input int c, input int s,
      input logic [5:0] o, input logic rs, input logic rn);
    logic sel, irw, rw, rdst, asa, mw, m2r, beq, pcw, hlt;
    logic [1:0] asb, pcsrc;
    {sel, irw, rw, rdst, asa, mw, m2r, beq, pcw, hlt} = '0;
    asb = 2'b00;
    pcsrc = 2'b00;
    if (s == 0) irw = 1'b1;
    else if (s == 1) pcw = (c == C_ILL);
    else begin
      case (c)
        C_R: begin
          asa = 1'b1;
          if (s == 3) {rw, rdst, pcw} = 3'b111;
        end
        C_I: begin
          asa = 1'b1;
          asb = 2'b10;
          if (s == 3) {rw, rdst, pcw} = 3'b111;
        end
        C_LW: begin
          if (s == 2) begin asa = 1'b1; asb = 2'b10; end
          if (s == 3) sel = 1'b1;
          if (s == 4) {rw, rdst, m2r, pcw} = 4'b1111;
        end
        C_SW: begin
          if (s == 2) begin asa = 1'b1; asb = 2'b10; end
          if (s == 3) {mw, pcw} = 2'b11;
        end
        C_BR: begin
          asa = 1'b1;
          beq = ~o[0];
          pcsrc = 2'b01;
          pcw = 1'b1;
        end
        C_J: begin
          pcsrc = 2'b10;
          pcw = 1'b1;
        end
        C_HALT:  hlt = 1'b1;
        default: ;
      endcase
    end
    if (!rn) {irw, rw, mw, pcw} = 4'b0000;
    if (rs) return '0;
    return {sel, irw, rw, rdst, asa, asb, mw, m2r, beq, pcsrc, pcw, pcw, hlt};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_hist();
    {h_irw, h_rw, h_pcw, h_mw, h_sel, h_m2r} = '0;
    last_pcsrc = 2'b11;
    last_beq = 1'bx;
    n_halt = 0;
  endtask

  task automatic step_cycle(input logic r, input logic rn, input logic [5:0] o);
    int c;
    logic [5:0] oo;
    logic [14:0] exp, act;
    logic [63:0] exp_cnt;
    @(negedge clk);
    reset = r;
    run = rn;
    opcode = o;
    #1;
    c = (step == 1) ? classify(o) : cls;
    oo = (step == 1) ? o : op_m;
    exp = model_out(c, step, oo, r, rn);
    act = {SelectIns, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB,
           MemWrite, MemtoReg, BEQ, PCSrc, PCWrite, instr_done, halted};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs step=%0d op=%b run=%b rst=%b: got %b expected %b",
               step, o, rn, r, act, exp);
    end
`ifdef PERF_CNT_EN
    exp_cnt = r ? 64'd0 : {m_instr, m_cyc};
`else
    exp_cnt = 64'd0;
`endif
    checks++;
    if ({instr_cnt, cycle_cnt} !== exp_cnt) begin
      errors++;
      $display("FAIL counters: got %0d/%0d expected %0d/%0d",
               instr_cnt, cycle_cnt, exp_cnt[63:32], exp_cnt[31:0]);
    end
    if (r) check("state_dbg_in_reset", {28'd0, state_dbg}, 32'd0);
    h_irw = {h_irw[6:0], IRWrite};
    h_rw  = {h_rw[6:0], RegWrite};
    h_pcw = {h_pcw[6:0], PCWrite};
    h_mw  = {h_mw[6:0], MemWrite};
    h_sel = {h_sel[6:0], SelectIns};
    h_m2r = {h_m2r[6:0], MemtoReg};
    if (PCWrite) begin
      last_pcsrc = PCSrc;
      last_beq = BEQ;
    end
    if (halted) n_halt++;
    @(posedge clk);
    if (r) begin
      step = 0;
      m_instr = '0;
      m_cyc = '0;
    end else if (rn) begin
      if (!(cls == C_HALT && step >= 2)) m_cyc++;
      if (exp[1]) m_instr++;
      if (step == 1) begin
        cls = c;
        op_m = o;
      end
      if (cls == C_HALT && step >= 1) step = 2;
      else if (step == ilen(cls) - 1) step = 0;
      else step++;
    end
  endtask

  task automatic run_op(input logic [5:0] o, input int n);
    clear_hist();
    repeat (n) step_cycle(1'b0, 1'b1, o);
  endtask

  logic [5:0] picks [8];

  initial begin
    picks = '{6'b000010, 6'b010101, 6'b100000, 6'b100001,
              6'b100010, 6'b110000, 6'b110001, 6'b100011};
    reset = 1'b1;
    run = 1'b1;
    opcode = '0;
    clear_hist();
    step_cycle(1'b1, 1'b1, 6'b000010);
    step_cycle(1'b1, 1'b1, 6'b000010);
    check("reset_no_irwrite", {30'd0, h_irw[1:0]}, 32'd0);

    run_op(6'b000010, 4);
    check("r_irwrite", {28'd0, h_irw[3:0]}, 32'b1000);
    check("r_regwrite", {28'd0, h_rw[3:0]}, 32'b0001);
    check("r_pcwrite", {28'd0, h_pcw[3:0]}, 32'b0001);
    check("r_pcsrc", {30'd0, last_pcsrc}, 32'd0);

    run_op(6'b110000, 5);
    check("lw_selectins", {27'd0, h_sel[4:0]}, 32'b00010);
    check("lw_regwrite", {27'd0, h_rw[4:0]}, 32'b00001);
    check("lw_memtoreg", {27'd0, h_m2r[4:0]}, 32'b00001);

    run_op(6'b110001, 4);
    check("sw_memwrite", {28'd0, h_mw[3:0]}, 32'b0001);
    check("sw_regwrite", {28'd0, h_rw[3:0]}, 32'd0);
`ifdef PERF_CNT_EN
    #1;
    check("perf_instr", instr_cnt, 32'd3);
    check("perf_cycle", cycle_cnt, 32'd13);
`endif

    run_op(6'b100001, 3);
    check("bne_pcwrite", {29'd0, h_pcw[2:0]}, 32'b001);
    check("bne_beq", {31'd0, last_beq}, 32'd0);
    check("bne_pcsrc", {30'd0, last_pcsrc}, 32'b01);

    run_op(6'b100010, 3);
    check("jmp_pcsrc", {30'd0, last_pcsrc}, 32'b10);

    clear_hist();
    repeat (3) step_cycle(1'b0, 1'b1, 6'b110001);
    repeat (3) step_cycle(1'b0, 1'b0, 6'b110001);
    step_cycle(1'b0, 1'b1, 6'b110001);
    check("stall_memwrite", {25'd0, h_mw[6:0]}, 32'b0000001);
    check("stall_pcwrite", {25'd0, h_pcw[6:0]}, 32'b0000001);

    run_op(6'b110000, 2);
    step_cycle(1'b1, 1'b1, 6'b110000);
    check("mid_reset_strobes", {24'd0, h_irw | h_rw | h_pcw} & 32'b1, 32'd0);
    run_op(6'b110000, 5);
    check("after_reset_fetch", {27'd0, h_irw[4:0]}, 32'b10000);

    run_op(6'b111111, 22);
    check("halt_cycles", n_halt, 32'd20);
    check("halt_no_pcwrite", {24'd0, h_pcw}, 32'd0);

    step_cycle(1'b1, 1'b1, 6'b000000);
    for (int i = 0; i < 3000; i++) begin
      logic r, rn;
      logic [5:0] o;
      r = ($urandom_range(99) == 0);
      rn = ($urandom_range(9) != 0);
      if ($urandom_range(7) == 0) o = 6'($urandom);
      else o = picks[$urandom_range(7)];
      step_cycle(r, rn, o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
